// File: rtl/program_loader.sv
// Program loader: buffers an external byte stream and hands it to the control block's
// programming micro-ops, entering and leaving programming mode on instruction-cycle boundaries.
module program_loader #(
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  input  logic                         cpu_ready,
  input  logic                         read_ui_in,
  input  logic                         done_load,
  output logic                         programming,
  output logic [7:0]                   load_data,
  output logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         underrun
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NW = $clog2(MEM_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC_IN  = 3'd1,
    LOAD     = 3'd2,
    SYNC_OUT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [NW-1:0] acc_q, acc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          prog_q, prog_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;

  logic fifo_full, fifo_empty, push, pop;

  assign busy       = (state_q == SYNC_IN) || (state_q == LOAD) || (state_q == SYNC_OUT);
  assign fifo_full  = (occ_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign byte_ready = busy && !fifo_full && (acc_q < NW'(MEM_DEPTH));
  assign push       = byte_valid && byte_ready;
  assign pop        = (state_q == LOAD) && done_load && !fifo_empty;

  // Bus data is the FIFO head only during a read request; an empty FIFO writes zero.
  assign load_data   = (!fifo_empty && read_ui_in) ? fifo_q[rd_ptr_q] : 8'h00;
  assign programming = prog_q;
  assign load_addr   = addr_q;
  assign done        = done_q;
  assign underrun    = underrun_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    prog_d     = prog_q;
    done_d     = done_q;
    underrun_d = underrun_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = SYNC_IN;
          done_d     = 1'b0;
          underrun_d = 1'b0;
          acc_d      = '0;
          addr_d     = '0;
          occ_d      = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
        end
      end
      SYNC_IN: begin
        if (cpu_ready) begin
          prog_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (read_ui_in && fifo_empty) begin
          underrun_d = 1'b1;
        end
        if (done_load) begin
          addr_d = AW'(addr_q + AW'(1));
          if (addr_q == AW'(MEM_DEPTH - 1)) begin
            state_d = SYNC_OUT;
          end
        end
      end
      SYNC_OUT: begin
        if (cpu_ready) begin
          prog_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Push/pop only happen while busy, so they never collide with the start-time clear.
    if (push) begin
      wr_ptr_d = PW'(wr_ptr_q + PW'(1));
      acc_d    = NW'(acc_q + NW'(1));
    end
    if (pop) begin
      rd_ptr_d = PW'(rd_ptr_q + PW'(1));
    end
    if (push || pop) begin
      occ_d = CW'(occ_q + CW'(push) - CW'(pop));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      prog_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      prog_q     <= prog_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= byte_in;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a 7-phase control-block stub drives the strobes, and a
// scoreboard checks every RAM write (data and address) plus mode-switch timing.
module tb_program_loader;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, byte_valid;
  logic [7:0] byte_in;
  logic       cpu_ready  = 1'b0;
  logic       read_ui_in = 1'b0;
  logic       done_load  = 1'b0;
  logic       byte_ready, programming, busy, done, underrun;
  logic [7:0] load_data;
  logic [3:0] load_addr;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rd_cnt      = 0;
  int   wcnt        = 0;
  bit   check_rr    = 1'b0;
  int   phase       = 6;

  always #5 clk = ~clk;

  program_loader #(.MEM_DEPTH(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .cpu_ready(cpu_ready),
    .read_ui_in(read_ui_in), .done_load(done_load), .programming(programming),
    .load_data(load_data), .load_addr(load_addr), .busy(busy), .done(done),
    .underrun(underrun)
  );

  // Control-block stub: phase 0 = T0 (ready), 3 = T3 (read), 4 = T4 (RAM write), 6 = stage 6.
  always @(negedge clk) begin
    int nxt;
    nxt = reset ? 0 : ((phase == 6) ? 0 : phase + 1);
    phase      <= nxt;
    cpu_ready  <= (nxt == 0);
    read_ui_in <= programming && (nxt == 3);
    done_load  <= programming && (nxt == 4);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit before each posedge.
  initial begin
    logic [7:0] cap;
    logic       prog_prev, rdy_prev, rst_prev, done_prev, wrote_prev;
    exp_t       e;
    cap = 8'h00; prog_prev = 1'b0; rdy_prev = 1'b0; rst_prev = 1'b1;
    done_prev = 1'b0; wrote_prev = 1'b0;
    forever begin
      @(negedge clk); #4;
      if (read_ui_in) begin
        cap = load_data;
        rd_cnt++;
      end
      if (check_rr && wrote_prev && wcnt <= 14) chk("ready_rerise", 32'(byte_ready), 1);
      wrote_prev = 1'b0;
      if (done_load) begin
        if (exp_q.size() == 0) begin
          chk("write_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("ram_data", 32'(cap), 32'(e.data));
          chk("ram_addr", 32'(load_addr), 32'(e.addr));
        end
        wcnt++;
        wrote_prev = 1'b1;
      end
      if (programming !== prog_prev && !rst_prev) begin
        chk("prog_switch_at_T0", 32'(rdy_prev), 1);
        if (!programming) chk("done_rise_with_prog_fall", 32'({done_prev, done}), 32'h1);
      end
      prog_prev = programming;
      rdy_prev  = cpu_ready;
      rst_prev  = reset;
      done_prev = done;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_image(input logic [7:0] base, input int stall_at);
    logic [7:0] d;
    for (int w = 0; w < 16; w++) begin
      if (stall_at < 0 || w < stall_at) d = base + 8'(w);
      else if (w == stall_at)           d = 8'h00;
      else                              d = base + 8'(w - 1);
      exp_q.push_back({d, 4'(w)});
    end
  endtask

  task automatic feed(input logic [7:0] base, input int n, input int stall_at, input bit chk_full);
    for (int i = 0; i < n; i++) begin
      int g;
      bit acc;
      if (i == stall_at) begin
        byte_valid = 1'b0;
        g = 0;
        while (rd_cnt < stall_at + 1 && g < 500) begin
          @(posedge clk); #1;
          g++;
        end
      end
      byte_in    = base + 8'(i);
      byte_valid = 1'b1;
      g = 0;
      acc = 1'b0;
      do begin
        @(negedge clk); #4;
        acc = byte_ready;
        if (chk_full && i == 2 && g == 0) chk("ready_low_when_full", 32'(acc), 0);
        @(posedge clk); #1;
        g++;
      end while (!acc && g < 500);
      if (!acc) chk("feed_timeout", 32'(acc), 1);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int g;
    g = 0;
    while (wcnt < n && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    if (wcnt < n) chk("write_count_timeout", wcnt, n);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (done !== 1'b1 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk("done_reached", 32'(done), 1);
  endtask

  task automatic end_checks(input logic exp_underrun);
    chk("end_programming", 32'(programming), 0);
    chk("end_busy",        32'(busy), 0);
    chk("end_underrun",    32'(underrun), 32'(exp_underrun));
    chk("end_load_addr",   32'(load_addr), 0);
    chk("end_queue_empty", exp_q.size(), 0);
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_programming"}, 32'(programming), 0);
    chk({tag, "_busy"},        32'(busy), 0);
    chk({tag, "_done"},        32'(done), 0);
    chk({tag, "_underrun"},    32'(underrun), 0);
    chk({tag, "_byte_ready"},  32'(byte_ready), 0);
    chk({tag, "_load_addr"},   32'(load_addr), 0);
    chk({tag, "_load_data"},   32'(load_data), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    zero_checks("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Image 1: continuous stream, full-FIFO backpressure, start ignored mid-load.
    rd_cnt = 0; wcnt = 0; check_rr = 1'b1;
    push_image(8'h10, -1);
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    fork
      feed(8'h10, 16, -1, 1'b1);
      begin
        wait_writes(5);
        pulse_start();
        chk("ign_start_busy",  32'(busy), 1);
        chk("ign_start_prog",  32'(programming), 1);
        chk("ign_start_addr",  32'(load_addr), 5);
        chk("ign_start_done",  32'(done), 0);
      end
    join
    wait_done();
    check_rr = 1'b0;
    end_checks(1'b0);

    // Image 2: reload straight from DONE.
    rd_cnt = 0; wcnt = 0;
    push_image(8'hA0, -1);
    pulse_start();
    chk("reload_done_clear", 32'(done), 0);
    chk("reload_busy",       32'(busy), 1);
    feed(8'hA0, 16, -1, 1'b0);
    wait_done();
    end_checks(1'b0);

    // Image 3: source stalls before byte 5 past its T3 -> zero written, order kept.
    rd_cnt = 0; wcnt = 0;
    push_image(8'h30, 5);
    pulse_start();
    feed(8'h30, 16, 5, 1'b0);
    wait_done();
    end_checks(1'b1);

    // Image 4: reset after 7 writes.
    rd_cnt = 0; wcnt = 0;
    for (int w = 0; w < 7; w++) exp_q.push_back({8'h60 + 8'(w), 4'(w)});
    pulse_start();
    feed(8'h60, 9, -1, 1'b0);
    wait_writes(7);
    reset = 1'b1;
    @(posedge clk); #1;
    zero_checks("midreset");
    chk("midreset_queue_empty", exp_q.size(), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Image 5: fresh load after reset starts from address 0.
    rd_cnt = 0; wcnt = 0;
    push_image(8'h70, -1);
    pulse_start();
    chk("post_reset_done_clear", 32'(done), 0);
    feed(8'h70, 16, -1, 1'b0);
    wait_done();
    end_checks(1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequences the control block's programming mode so the 16-byte RAM can be filled from an external byte stream. It buffers bytes from the input pins and drives them onto the bus when the control block requests input data. It raises and drops `programming` only on instruction-cycle boundaries, and counts completed RAM writes. It sits between the top-level `ui_in` pins and the control block, and owns the `programming` input of that block.

## Interface
- `MEM_DEPTH`, 16: bytes per program image; also the number of RAM writes before programming ends.
- `FIFO_DEPTH`, 2: entries in the input byte buffer (power of two, ≥2).
- `clk`  in  1  system clock, same clock as the control block.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begins a load when idle or done.
- `byte_in`  in  8  program byte from pins.
- `byte_valid`  in  1  `byte_in` valid this cycle.
- `byte_ready`  out  1  loader accepts `byte_in` this cycle.
- `cpu_ready`  in  1  control block `ready` (T0 marker).
- `read_ui_in`  in  1  control block request for bus data (T3).
- `done_load`  in  1  control block RAM-write strobe (T4).
- `programming`  out  1  to control block; selects programming micro-ops.
- `load_data`  out  8  byte driven onto bus while `read_ui_in` is high.
- `load_addr`  out  log2(MEM_DEPTH)  number of RAM writes completed so far.
- `busy`  out  1  a load is in progress.
- `done`  out  1  sticky; full image written.
- `underrun`  out  1  sticky; a write occurred with an empty buffer.

## Operation
- States: IDLE, SYNC_IN, LOAD, SYNC_OUT, DONE.
- IDLE: on `start`, clear `done`, `underrun`, counters and FIFO, then go to SYNC_IN.
- SYNC_IN: wait for `cpu_ready` high at a posedge. At that edge set `programming`=1 and go to LOAD. `programming` therefore changes only while the control block is moving from T0 to T1.
- LOAD:
  - Accept bytes: `byte_ready` = busy AND FIFO not full AND accepted count < MEM_DEPTH.
  - A push occurs on `byte_valid && byte_ready`.
  - `load_data` = FIFO head when the FIFO is non-empty and `read_ui_in`=1. Otherwise `load_data` = 0x00. It is combinational from the head register.
  - On a posedge with `read_ui_in`=1 and the FIFO empty: set `underrun`. 0x00 is written to RAM.
  - On a posedge with `done_load`=1: pop the FIFO if non-empty, then increment `load_addr`.
  - When `load_addr` reaches MEM_DEPTH-1 and `done_load` is seen, go to SYNC_OUT.
- SYNC_OUT: on the next `cpu_ready` posedge, clear `programming`, set `done`, and go to DONE. The PC has wrapped to 0, so execution starts at address 0.
- DONE: `start` behaves as in IDLE, so the block can be reloaded.
- `start` while `busy` is ignored.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- `byte_valid` while `byte_ready`=0 is dropped. The source must hold the byte until it sees `byte_ready`.
- `load_addr` wraps to 0 on the final write (4-bit wrap for depth 16).
- `busy` = state ∈ {SYNC_IN, LOAD, SYNC_OUT}.

## Timing
- Reset: state IDLE; all outputs 0, including `load_data`=0x00, `programming`=0 and `byte_ready`=0. The FIFO is empty and the counters are 0.
- Reset applies mid-load: `programming` drops at the next posedge. The control block must be reset by the same system reset.
- Control-block strobes change on negedge; the loader samples them on posedge only.
- `start` to `programming`: 1 cycle to SYNC_IN, then up to 7 cycles waiting for T0.
- A byte pushed at posedge N is visible on `load_data` from posedge N+1. It must be pushed before the posedge that precedes T3 of its instruction cycle.
- One RAM write per 7-cycle control-block loop (stage 6 plus T0–T5). A full image takes ≥ MEM_DEPTH × 7 cycles.
- `done` rises in the same cycle `programming` falls.

## Test plan
- Reset, then `start`, then stream 0x10..0x1F with `byte_valid` held continuously:
  - `programming` rises at the first T0.
  - Each of the 16 `done_load` strobes sees `load_data` equal to the next byte, and `load_addr` runs 0→15→0.
  - `done`=1, `programming`=0 at the following T0, and `underrun`=0.
- Source stalls before byte 5 until after T3 of that write: `underrun`=1, the RAM gets 0x00, and the remaining bytes stay in order.
- Feed bytes faster than writes: `byte_ready` drops after 2 buffered bytes and re-rises on each `done_load`; no bytes are lost.
- Pulse `start` during LOAD: no effect on state, counters or `done`.
- Assert `reset` after 7 writes: all outputs are 0 next cycle. A subsequent `start` reloads from address 0 with `done` clear.
- After DONE, pulse `start` again: `done` clears, and a second image 0xA0..0xAF loads correctly.
